// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: default widths,
// the sequencing state encoding and the grant identifiers.
package ram_arb_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic GNT_P0 = 1'b0;
    localparam logic GNT_P1 = 1'b1;

endpackage

// File: rtl/ram_arbiter_rr.sv
// Two-way round-robin pick. Purely combinational; the history bit
// (last_grant) is owned by the parent so it only advances on a real grant.
module rr_arbiter_2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);

    // Lone requester wins; on a tie the port that did not win last time goes.
    always_comb begin
        grant_valid = |req;
        grant_id    = GNT_P0;
        if (req == 2'b11) begin
            grant_id = ~last_grant;
        end else if (req[1]) begin
            grant_id = GNT_P1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Sequencing arbiter in front of the single-port data RAM.
// Each access takes IDLE -> ACCESS -> RESP, so one access per three cycles.
// Optional feature macro: RAM_ARB_PROT_EN (port-0 writes at or above
// PROT_BASE are suppressed and flagged on p0_err).
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter int                DATA_W    = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] PROT_BASE = 8'hC0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_t            state;
    logic              we_q;
    logic              prot_q;
    logic              gnt_q;
    logic              last_grant;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic              grant_valid;
    logic              grant_id;
    logic              sel_we;
    logic              sel_prot;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arbiter_2 u_rr (
        .req         ({p1_req, p0_req}),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Fields of the winning port, latched when leaving IDLE.
    assign sel_we    = (grant_id == GNT_P1) ? p1_we    : p0_we;
    assign sel_addr  = (grant_id == GNT_P1) ? p1_addr  : p0_addr;
    assign sel_wdata = (grant_id == GNT_P1) ? p1_wdata : p0_wdata;

`ifdef RAM_ARB_PROT_EN
    // Only port-0 writes into the upper region are blocked.
    assign sel_prot = (grant_id == GNT_P0) && p0_we && (p0_addr >= PROT_BASE);
`else
    // Without protection the base address has no role.
    logic unused_prot;
    assign sel_prot    = 1'b0;
    assign unused_prot = ^PROT_BASE;
`endif

    // Single-FSM sequencer: latches the winner, strobes the RAM for one
    // cycle, then returns a one-cycle ack to the granted port. Strobes are
    // flops with async reset so they fall the moment rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            prot_q     <= 1'b0;
            gnt_q      <= GNT_P0;
            last_grant <= GNT_P1;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            p0_ack     <= 1'b0;
            p1_ack     <= 1'b0;
            p0_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    p0_ack <= 1'b0;
                    p1_ack <= 1'b0;
                    p0_err <= 1'b0;
                    if (grant_valid) begin
                        state      <= ACCESS;
                        gnt_q      <= grant_id;
                        last_grant <= grant_id;
                        we_q       <= sel_we;
                        prot_q     <= sel_prot;
                        addr_q     <= sel_addr;
                        wdata_q    <= sel_wdata;
                        mem_read   <= !sel_we;
                        mem_write  <= sel_we && !sel_prot;
                    end
                end
                ACCESS: begin
                    state     <= RESP;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    rdata_q   <= we_q ? '0 : mem_rdata;
                    p0_ack    <= (gnt_q == GNT_P0);
                    p1_ack    <= (gnt_q == GNT_P1);
                    p0_err    <= prot_q && (gnt_q == GNT_P0);
                end
                RESP: begin
                    state  <= IDLE;
                    p0_ack <= 1'b0;
                    p1_ack <= 1'b0;
                    p0_err <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    p0_ack    <= 1'b0;
                    p1_ack    <= 1'b0;
                    p0_err    <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign p0_rdata  = p0_ack ? rdata_q : '0;
    assign p1_rdata  = p1_ack ? rdata_q : '0;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: a vector table, hand-written
// sequences for the multi-cycle corners, and a randomized run checked
// against a transaction-level model (pending requests, round-robin history
// bit, and a reference copy of the RAM contents).
module tb_ram_arbiter;

    localparam int         AW = 8;
    localparam int         DW = 16;
    localparam logic [7:0] PB = 8'hC0;
`ifdef RAM_ARB_PROT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          p0_req, p0_we, p0_ack, p0_err;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata, p0_rdata;
    logic          p1_req, p1_we, p1_ack;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata, p1_rdata;
    logic          mem_read, mem_write, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PROT_BASE(PB)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input int a);
        return 16'((a * 37) + 16'h1000);
    endfunction

    // Behavioural single-port RAM with combinational read.
    logic [15:0] ram [256];
    logic        init_req;
    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
        end else if (mem_write) begin
            ram[mem_addr] <= mem_wdata;
        end
    end

    typedef struct {
        bit          act;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
    } req_t;

    typedef struct {
        int          port;
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
    } vec_t;

    req_t        pend [2];
    bit          lg_m;
    logic [15:0] ref_mem [256];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive_reqs();
        p0_req   = pend[0].act;
        p0_we    = pend[0].we;
        p0_addr  = pend[0].addr;
        p0_wdata = pend[0].wdata;
        p1_req   = pend[1].act;
        p1_we    = pend[1].we;
        p1_addr  = pend[1].addr;
        p1_wdata = pend[1].wdata;
    endtask

    task automatic clear_pend();
        for (int p = 0; p < 2; p++) pend[p] = '{1'b0, 1'b0, 8'h00, 16'h0000};
        drive_reqs();
    endtask

    // Called at a falling edge with the DUT in IDLE; runs one whole access.
    task automatic serve_one(input string nm, input bit keep, output int won,
                             output logic [15:0] got_rd, output logic got_err);
        int          w;
        bit          prot;
        logic [15:0] exp_rd;
        drive_reqs();
        if (pend[0].act && pend[1].act) w = lg_m ? 0 : 1;
        else                            w = pend[0].act ? 0 : 1;
        lg_m   = (w == 1);
        prot   = PROT_EN && (w == 0) && pend[w].we && (pend[w].addr >= PB);
        exp_rd = pend[w].we ? 16'h0000 : ref_mem[pend[w].addr];
        won    = w;
        @(negedge clk);
        check({nm, ":acc_busy"}, 32'(busy), 32'(1));
        check({nm, ":acc_addr"}, 32'(mem_addr), 32'(pend[w].addr));
        check({nm, ":acc_wr"}, 32'(mem_write), 32'(pend[w].we && !prot));
        check({nm, ":acc_rd"}, 32'(mem_read), 32'(!pend[w].we));
        check({nm, ":acc_acks"}, 32'({p0_ack, p1_ack}), 32'(0));
        if (pend[w].we) check({nm, ":acc_wdata"}, 32'(mem_wdata), 32'(pend[w].wdata));
        @(negedge clk);
        check({nm, ":p0_ack"}, 32'(p0_ack), 32'(w == 0));
        check({nm, ":p1_ack"}, 32'(p1_ack), 32'(w == 1));
        check({nm, ":p0_rdata"}, 32'(p0_rdata), 32'((w == 0) ? exp_rd : 16'h0));
        check({nm, ":p1_rdata"}, 32'(p1_rdata), 32'((w == 1) ? exp_rd : 16'h0));
        check({nm, ":p0_err"}, 32'(p0_err), 32'(prot));
        check({nm, ":resp_strobes"}, 32'({mem_read, mem_write}), 32'(0));
        got_rd  = (w == 0) ? p0_rdata : p1_rdata;
        got_err = p0_err;
        if (pend[w].we && !prot) ref_mem[pend[w].addr] = pend[w].wdata;
        if (!keep) begin
            pend[w].act = 1'b0;
            drive_reqs();
        end
        @(negedge clk);
        check({nm, ":idle_busy"}, 32'(busy), 32'(0));
        check({nm, ":idle_acks"}, 32'({p0_ack, p1_ack}), 32'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_pend();
        #1;
        check("rst_acks", 32'({p0_ack, p1_ack, p0_err}), 32'(0));
        check("rst_strobes", 32'({mem_read, mem_write}), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_addr", 32'(mem_addr), 32'(0));
        check("rst_wdata", 32'(mem_wdata), 32'(0));
        check("rst_rdata", 32'({p0_rdata, p1_rdata}), 32'(0));
        @(negedge clk);
        rst  = 1'b0;
        lg_m = 1'b1;
    endtask

    vec_t tbl [10];

    initial begin
        int          won;
        logic [15:0] rd;
        logic        er;

        tbl[0] = '{0, 1'b1, 8'h10, 16'hBEEF, 16'h0000};
        tbl[1] = '{0, 1'b0, 8'h10, 16'h0000, 16'hBEEF};
        tbl[2] = '{1, 1'b1, 8'h11, 16'h1234, 16'h0000};
        tbl[3] = '{1, 1'b0, 8'h10, 16'h0000, 16'hBEEF};
        tbl[4] = '{0, 1'b0, 8'h11, 16'h0000, 16'h1234};
        tbl[5] = '{1, 1'b1, 8'h10, 16'hA5A5, 16'h0000};
        tbl[6] = '{0, 1'b0, 8'h10, 16'h0000, 16'hA5A5};
        tbl[7] = '{1, 1'b1, 8'hFF, 16'hFFFF, 16'h0000};
        tbl[8] = '{0, 1'b0, 8'hFF, 16'h0000, 16'hFFFF};
        tbl[9] = '{1, 1'b0, 8'h00, 16'h0000, init_val(0)};

        rst      = 1'b1;
        init_req = 1'b1;
        clear_pend();
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        @(negedge clk);
        init_req = 1'b0;
        do_reset();

        // Vector table: one transaction per row.
        for (int i = 0; i < 10; i++) begin
            pend[tbl[i].port] = '{1'b1, tbl[i].we, tbl[i].addr, tbl[i].wdata};
            serve_one($sformatf("tbl%0d", i), 1'b0, won, rd, er);
            check($sformatf("tbl%0d:rd", i), 32'(rd), 32'(tbl[i].exp_rd));
        end

        // Simultaneous reads right after reset: port 0 first, twice over.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            pend[0] = '{1'b1, 1'b0, 8'h10, 16'h0};
            pend[1] = '{1'b1, 1'b0, 8'h11, 16'h0};
            serve_one("tie_a", 1'b0, won, rd, er);
            check("tie_first", 32'(won), 32'(0));
            serve_one("tie_b", 1'b0, won, rd, er);
            check("tie_second", 32'(won), 32'(1));
        end

        // Both ports hold req for six back-to-back transactions.
        pend[0] = '{1'b1, 1'b0, 8'h10, 16'h0};
        pend[1] = '{1'b1, 1'b1, 8'h30, 16'h5555};
        for (int t = 0; t < 6; t++) begin
            serve_one($sformatf("cont%0d", t), 1'b1, won, rd, er);
            check($sformatf("cont%0d:order", t), 32'(won), 32'(t % 2));
        end
        clear_pend();

        // Reset in the middle of a port-1 write: nothing commits, no ack.
        pend[1] = '{1'b1, 1'b1, 8'h20, 16'h1234};
        drive_reqs();
        @(negedge clk);
        check("mid_wr_before", 32'(mem_write), 32'(1));
        #1 rst = 1'b1;
        #1;
        check("mid_wr_drop", 32'(mem_write), 32'(0));
        check("mid_rd_drop", 32'(mem_read), 32'(0));
        clear_pend();
        @(negedge clk);
        check("mid_no_ack_a", 32'(p1_ack), 32'(0));
        @(negedge clk);
        check("mid_no_ack_b", 32'(p1_ack), 32'(0));
        rst  = 1'b0;
        lg_m = 1'b1;
        check("mid_ram", 32'(ram[8'h20]), 32'(ref_mem[8'h20]));
        pend[0] = '{1'b1, 1'b0, 8'h20, 16'h0};
        serve_one("mid_rb", 1'b0, won, rd, er);
        check("mid_rb_val", 32'(rd), 32'(init_val(8'h20)));

        // Protected region behaviour (active only when the feature is built in).
        pend[0] = '{1'b1, 1'b1, 8'hC5, 16'hCAFE};
        serve_one("prot_w0", 1'b0, won, rd, er);
        check("prot_err", 32'(er), 32'(PROT_EN));
        pend[1] = '{1'b1, 1'b0, 8'hC5, 16'h0};
        serve_one("prot_r1", 1'b0, won, rd, er);
        check("prot_r1_val", 32'(rd), 32'(PROT_EN ? init_val(8'hC5) : 16'hCAFE));
        pend[1] = '{1'b1, 1'b1, 8'hC5, 16'h7777};
        serve_one("prot_w1", 1'b0, won, rd, er);
        pend[0] = '{1'b1, 1'b0, 8'hC5, 16'h0};
        serve_one("prot_r0", 1'b0, won, rd, er);
        check("prot_r0_val", 32'(rd), 32'(16'h7777));

        // Randomized traffic against the transaction-level model.
        for (int it = 0; it < 200; it++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p].act && ($urandom_range(0, 1) == 1)) begin
                    pend[p].act   = 1'b1;
                    pend[p].we    = 1'($urandom_range(0, 1));
                    pend[p].addr  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(8'hBE, 8'hC8))
                                                                : 8'($urandom_range(0, 15));
                    pend[p].wdata = 16'($urandom);
                end
            end
            if (!pend[0].act && !pend[1].act) begin
                @(negedge clk);
                check("rnd_idle_busy", 32'(busy), 32'(0));
            end else begin
                serve_one("rnd", 1'b0, won, rd, er);
            end
        end
        clear_pend();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port sequencing arbiter in front of the single-port 256x16 data RAM.
- Lets the CPU data path (port 0) and the program loader/debug path (port 1) share the RAM.
- Serialises accesses with round-robin fairness and registers read data.
- Drives the RAM's read/write strobes, address and write data; the RAM's combinational read output is sampled inside the block.

## Interface
Parameters:
- ADDR_W, 8, address width (256 words).
- DATA_W, 16, data word width.
- PROT_BASE, 8'hC0, first address of the port-0 write-protected region (used only with RAM_ARB_PROT_EN).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- p0_req  in  1  port 0 request; hold high, with fields stable, until p0_ack.
- p0_we  in  1  port 0 access type: 1 = write, 0 = read.
- p0_addr  in  ADDR_W  port 0 word address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_ack  out  1  one-cycle completion pulse for port 0.
- p0_rdata  out  DATA_W  port 0 read data; valid while p0_ack is high.
- p0_err  out  1  protection violation flag; pulses together with p0_ack.
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata: same rules as port 0 (port 1 has no err output).
- mem_read  out  1  RAM read strobe.
- mem_write  out  1  RAM write strobe.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM combinational read data.
- busy  out  1  high in every state except IDLE.

## Operation
States:
- IDLE
  - No request: stay in IDLE.
  - Any request: pick a winner, latch its we/addr/wdata and the grant id, go to ACCESS.
- ACCESS
  - Drive mem_addr and mem_wdata from the latched values.
  - mem_read = !we_q; mem_write = we_q.
  - On the clock edge: the RAM commits a write, or mem_rdata is captured into rdata_q. Go to RESP.
- RESP
  - Assert the granted port's ack with rdata = rdata_q.
  - rdata_q is 0 for writes.
  - Go to IDLE.

Arbitration:
- Only one port requesting: that port wins.
- Both ports requesting: the port other than last_grant wins; last_grant updates on every grant.
- Reset value of last_grant is 1, so port 0 wins the first tie.

Handshake:
- A request is sampled only in IDLE.
- A requester must drop req in the cycle after its ack unless it issues a new transaction.
- req, fields or requests from the other port that change during ACCESS or RESP have no effect on the transaction in flight.

Outputs:
- Strobes are 0 outside ACCESS.
- mem_addr and mem_wdata hold the latched values at all times.
- Non-granted port ack/rdata are 0.

## Timing
- Request high at edge k (state IDLE): ACCESS during cycle k+1, ack high during cycle k+2, IDLE again at k+3.
- Throughput: one access per 3 cycles; back-to-back alternating requesters are served in turn.
- Reset values: state IDLE; all acks, err, strobes and busy 0; rdata_q, latched addr and latched wdata 0; last_grant 1.
- Reset asserted during ACCESS: the strobes drop asynchronously, so no write commits on the next edge. The interrupted requester receives no ack.

## Configuration
RAM_ARB_PROT_EN

Defined:
- A port-0 write with addr >= PROT_BASE is suppressed: mem_write stays 0 in ACCESS.
- p0_ack still pulses, with p0_err = 1 in the same cycle.
- Port-0 reads and all port-1 accesses are unrestricted.

Undefined:
- p0_err is tied 0 and all writes commit.
- PROT_BASE is unused.

## Structure
- Package ram_arb_pkg: ADDR_W/DATA_W defaults, the state enum (IDLE, ACCESS, RESP), and the grant-id constants GNT_P0 = 0 and GNT_P1 = 1.
- Sub-module rr_arbiter_2: combinational 2-way round-robin pick from req[1:0] and last_grant.
  - Outputs grant_valid and grant_id.
  - last_grant is held in the parent.

## Test plan
- Single port-0 write: addr 0x10, data 0xBEEF. Required: mem_write is high for exactly one cycle (cycle k+1); p0_ack is high in cycle k+2. A following port-0 read of 0x10 returns p0_rdata = 0xBEEF with its ack.
- Simultaneous p0/p1 reads right after reset. Required: port 0 is served first and port 1 second. Then both request again: port 0 is served first once more, because last_grant = 1.
- Both ports hold req continuously for 6 transactions. Required: grants alternate 0,1,0,1,0,1 and each ack arrives 3 cycles after the previous one.
- Reset asserted mid-ACCESS of a p1 write of 0x1234 to 0x20. Required: mem_write drops immediately, no p1_ack is issued, and a later read of 0x20 returns the prior contents.
- With RAM_ARB_PROT_EN, port-0 write to 0xC5. Required: mem_write stays 0 and p0_ack and p0_err pulse together. A port-1 write to 0xC5 succeeds. Without the macro, the same port-0 write commits and p0_err stays 0.
- Port-1 read while port 0 is idle. Required: p0_ack and p0_rdata stay 0 throughout the transaction.
